// File: rtl/bo_horner_pkg.sv
// Shared definitions for the Horner polynomial evaluator.
//   state_e   : control FSM states (IDLE, MUL, ADD, DONE)
//   *_DEF     : default widths and degree
//   idx_width : width of a counter able to hold 0..n-1 (minimum 1 bit)
package bo_horner_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int XW_DEF     = 10;
  localparam int W_DEF      = 16;
  localparam int DEGREE_DEF = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bo_horner_if.sv
// Request/response bundle of the Horner evaluator.
//   start  : request, sampled only while the evaluator is idle
//   x      : operand, latched on accept
//   coef   : flattened coefficients, c[i] at [(i+1)*W-1:i*W], latched on accept
//   busy   : evaluation in progress
//   done   : one-cycle pulse, result/ovf valid
//   result : P(x) mod 2^W, held until the next evaluation completes
//   ovf    : some intermediate value exceeded W bits
// master = requester, slave = evaluator.
interface bo_horner_if
  import bo_horner_pkg::*;
#(
  parameter int XW     = XW_DEF,
  parameter int W      = W_DEF,
  parameter int DEGREE = DEGREE_DEF
) ();

  logic                      start;
  logic [XW-1:0]             x;
  logic [(DEGREE+1)*W-1:0]   coef;
  logic                      busy;
  logic                      done;
  logic [W-1:0]              result;
  logic                      ovf;

  modport master (output start, x, coef, input busy, done, result, ovf);
  modport slave  (input start, x, coef, output busy, done, result, ovf);

endinterface

// File: rtl/bo_horner_seq_mult.sv
// Iterative shift-add multiplier, one multiplier bit per step.
//   clock, reset : clock and asynchronous active-high reset
//   clr          : synchronous clear of the accumulator
//   step         : add a<<bit_idx when b[bit_idx] is set
//   a, b         : multiplicand (W bits), multiplier (XW bits)
//   bit_idx      : multiplier bit handled this step
//   acc          : full-width product accumulator (W+XW bits, cannot wrap)
module seq_mult
  import bo_horner_pkg::*;
#(
  parameter  int W  = W_DEF,
  parameter  int XW = XW_DEF,
  localparam int BW = idx_width(XW)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              step,
  input  logic [W-1:0]      a,
  input  logic [XW-1:0]     b,
  input  logic [BW-1:0]     bit_idx,
  output logic [W+XW-1:0]   acc
);

  logic [W+XW-1:0] r_acc;
  logic [W+XW-1:0] w_addend;

  assign w_addend = {{XW{1'b0}}, a} << bit_idx;

  // Partial-product accumulation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (step && b[bit_idx]) begin
      r_acc <= r_acc + w_addend;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/bo_horner.sv
// Polynomial evaluator P(x) = c[N]x^N + ... + c[0] using Horner's method.
// Each Horner step multiplies the running value S by x (XW shift-add cycles)
// then adds the next coefficient in one ADD cycle.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : start/x/coef in, busy/done/result/ovf out (slave modport)
module bo_horner
  import bo_horner_pkg::*;
#(
  parameter int XW     = XW_DEF,
  parameter int W      = W_DEF,
  parameter int DEGREE = DEGREE_DEF
) (
  input  logic         clock,
  input  logic         reset,
  bo_horner_if.slave   bus
);

  localparam int BW = idx_width(XW);
  localparam int IW = idx_width(DEGREE);
  localparam logic [BW-1:0] BIT_LAST  = BW'(XW - 1);
  localparam logic [IW-1:0] IDX_FIRST = IW'(DEGREE - 1);

  state_e                    r_state;
  logic [XW-1:0]             r_xr;
  logic [(DEGREE+1)*W-1:0]   r_cr;
  logic [W-1:0]              r_s;
  logic [IW-1:0]             r_idx;
  logic [BW-1:0]             r_bit;
  logic                      r_ovf_run;
  logic [W-1:0]              r_result;
  logic                      r_ovf;
  logic                      r_done;

  logic [W+XW-1:0]           w_acc;
  logic [W-1:0]              w_c_idx;
  logic [W:0]                w_sum;
  logic                      w_ovf_next;
  logic                      w_accept;
  logic                      w_clr;
  logic                      w_step;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  // Product is cleared when a new Horner step starts: at accept and after each ADD.
  assign w_clr    = w_accept || (r_state == S_ADD);
  assign w_step   = (r_state == S_MUL);

  assign w_c_idx    = r_cr[int'(r_idx) * W +: W];
  assign w_sum      = {1'b0, w_acc[W-1:0]} + {1'b0, w_c_idx};
  // Overflow if the product spilled above W bits or the add carried out.
  assign w_ovf_next = r_ovf_run | (|w_acc[W+XW-1:W]) | w_sum[W];

  seq_mult #(.W(W), .XW(XW)) u_mult (
    .clock   (clock),
    .reset   (reset),
    .clr     (w_clr),
    .step    (w_step),
    .a       (r_s),
    .b       (r_xr),
    .bit_idx (r_bit),
    .acc     (w_acc)
  );

  // Control FSM with the Horner registers and the registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_xr      <= '0;
      r_cr      <= '0;
      r_s       <= '0;
      r_idx     <= '0;
      r_bit     <= '0;
      r_ovf_run <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_xr      <= bus.x;
            r_cr      <= bus.coef;
            r_s       <= bus.coef[DEGREE*W +: W];
            r_idx     <= IDX_FIRST;
            r_bit     <= '0;
            r_ovf_run <= 1'b0;
            r_state   <= S_MUL;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_MUL: begin
          if (r_bit == BIT_LAST) begin
            r_state <= S_ADD;
          end else begin
            r_bit   <= r_bit + BW'(1);
          end
        end
        S_ADD: begin
          r_s       <= w_sum[W-1:0];
          r_ovf_run <= w_ovf_next;
          if (r_idx == '0) begin
            r_result <= w_sum[W-1:0];
            r_ovf    <= w_ovf_next;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_idx    <= r_idx - IW'(1);
            r_bit    <= '0;
            r_state  <= S_MUL;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_bo_horner.sv
// Self-checking bench for bo_horner: a default (degree 2) instance checked every
// cycle against a timeline/arithmetic model, plus a degree-3 instance.
module tb_bo_horner;

  localparam int XW = 10;
  localparam int W  = 16;
  localparam int DA = 2;
  localparam int DB = 3;
  localparam int LA = DA * (XW + 1);
  localparam int LB = DB * (XW + 1);

  logic clock = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clock = ~clock;

  bo_horner_if #(.XW(XW), .W(W), .DEGREE(DA)) io_a ();
  bo_horner_if #(.XW(XW), .W(W), .DEGREE(DB)) io_b ();

  bo_horner #(.XW(XW), .W(W), .DEGREE(DA)) dut_a (.clock(clock), .reset(rst_a), .bus(io_a.slave));
  bo_horner #(.XW(XW), .W(W), .DEGREE(DB)) dut_b (.clock(clock), .reset(rst_b), .bus(io_b.slave));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Horner evaluation on plain integers; ovf when a product or sum leaves W bits.
  function automatic void model(input int deg, input logic [63:0] cv, input int xv,
                                output int r, output bit o);
    longint s, p, t, c;
    s = longint'((cv >> (deg * 16)) & 64'hFFFF);
    o = 1'b0;
    for (int i = deg - 1; i >= 0; i--) begin
      c = longint'((cv >> (i * 16)) & 64'hFFFF);
      p = s * longint'(xv);
      if (p >= 65536) o = 1'b1;
      t = (p % 65536) + c;
      if (t >= 65536) o = 1'b1;
      s = t % 65536;
    end
    r = int'(s);
  endfunction

  function automatic logic [15:0] rnd_c();
    if ($urandom_range(0, 2) != 0) return 16'($urandom_range(0, 15));
    else return 16'($urandom);
  endfunction

  function automatic logic [63:0] rnd_coef();
    return {rnd_c(), rnd_c(), rnd_c(), rnd_c()};
  endfunction

  function automatic int rnd_x();
    if ($urandom_range(0, 1) != 0) return int'($urandom_range(0, 15));
    else return int'($urandom_range(0, 1023));
  endfunction

  // Instance A model: accept edge, expected outcome, and currently shown outputs.
  bit m_act   = 1'b0;
  int m_acc   = 0;
  int m_res   = 0;
  bit m_ovf   = 1'b0;
  int out_res = 0;
  bit out_ovf = 1'b0;

  // Per-cycle comparison of instance A against the model timeline.
  always @(negedge clock) begin
    bit eb, ed;
    eb = m_act && (cyc >= m_acc) && (cyc <= m_acc + LA);
    ed = m_act && (cyc == m_acc + LA);
    if (ed) begin
      out_res = m_res;
      out_ovf = m_ovf;
    end
    chk("busy_a",   64'(io_a.busy),   64'(eb));
    chk("done_a",   64'(io_a.done),   64'(ed));
    chk("result_a", 64'(io_a.result), 64'(out_res));
    chk("ovf_a",    64'(io_a.ovf),    64'(out_ovf));
  end

  // One cycle of stimulus on A, called at posedge+1; model decides acceptance.
  task automatic step_a(input bit st, input int xv, input logic [63:0] cv);
    int k;
    io_a.start = st;
    io_a.x     = 10'(xv);
    io_a.coef  = cv[47:0];
    k = cyc + 1;
    if (st && !(m_act && k <= m_acc + LA + 1)) begin
      m_act = 1'b1;
      m_acc = k;
      model(DA, {16'd0, cv[47:0]}, xv, m_res, m_ovf);
    end
    @(posedge clock);
    #1;
    io_a.start = 1'b0;
  endtask

  task automatic wait_done_a(output int lat, output bit seen);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < LA + 10; i++) begin
      step_a(1'b0, rnd_x(), rnd_coef());
      if (io_a.done) begin
        seen = 1'b1;
        lat  = cyc - m_acc;
        break;
      end
    end
    chk("done_seen_a", 64'(seen), 64'd1);
  endtask

  task automatic run_a(input int xv, input logic [63:0] cv, input int er, input bit eo);
    int lat;
    bit seen;
    step_a(1'b1, xv, cv);
    chk("busy_after_accept_a", 64'(io_a.busy), 64'd1);
    wait_done_a(lat, seen);
    if (seen) begin
      chk("latency_a", 64'(lat), 64'(LA));
      chk("lit_result_a", 64'(io_a.result), 64'(er));
      chk("lit_ovf_a", 64'(io_a.ovf), 64'(eo));
    end
    step_a(1'b0, 0, 64'd0);
  endtask

  task automatic run_b(input int xv, input logic [63:0] cv, input int er, input bit eo);
    int acc;
    bit seen;
    io_b.start = 1'b1;
    io_b.x     = 10'(xv);
    io_b.coef  = cv;
    acc = cyc + 1;
    @(posedge clock);
    #1;
    io_b.start = 1'b0;
    io_b.x     = 10'(rnd_x());
    io_b.coef  = rnd_coef();
    chk("busy_after_accept_b", 64'(io_b.busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < LB + 10; i++) begin
      @(posedge clock);
      #1;
      if (io_b.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen_b", 64'(seen), 64'd1);
    if (seen) begin
      chk("latency_b", 64'(cyc - acc), 64'(LB));
      chk("result_b", 64'(io_b.result), 64'(er));
      chk("ovf_b", 64'(io_b.ovf), 64'(eo));
    end
    @(posedge clock);
    #1;
    chk("done_pulse_b", 64'(io_b.done), 64'd0);
  endtask

  localparam logic [63:0] C221 = {16'd0, 16'd2, 16'd2, 16'd1};

  initial begin
    int r;
    bit o;
    logic [63:0] cv;
    int xv;
    io_a.start = 1'b0; io_a.x = '0; io_a.coef = '0;
    io_b.start = 1'b0; io_b.x = '0; io_b.coef = '0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clock);
    #1;
    chk("reset_busy_b",   64'(io_b.busy),   64'd0);
    chk("reset_done_b",   64'(io_b.done),   64'd0);
    chk("reset_result_b", 64'(io_b.result), 64'd0);
    chk("reset_ovf_b",    64'(io_b.ovf),    64'd0);
    @(posedge clock);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    step_a(1'b0, 0, 64'd0);

    // Directed cases on the default instance.
    run_a(3,    C221, 25,    1'b0);
    run_a(0,    C221, 1,     1'b0);
    run_a(1,    C221, 5,     1'b0);
    run_a(1023, C221, 63489, 1'b1);

    // Start while busy is ignored; a start on the edge leaving DONE is too.
    step_a(1'b1, 3, C221);
    repeat (4) step_a(1'b0, 7, C221);
    step_a(1'b1, 7, C221);
    begin
      int lat;
      bit seen;
      wait_done_a(lat, seen);
      if (seen) chk("ignored_start_result_a", 64'(io_a.result), 64'd25);
    end
    step_a(1'b1, 7, C221);
    step_a(1'b0, 0, 64'd0);
    run_a(7, C221, 113, 1'b0);

    // Reset in the middle of an evaluation.
    step_a(1'b1, 3, C221);
    repeat (9) step_a(1'b0, 5, C221);
    rst_a   = 1'b1;
    m_act   = 1'b0;
    out_res = 0;
    out_ovf = 1'b0;
    #1;
    chk("midreset_busy_a",   64'(io_a.busy),   64'd0);
    chk("midreset_done_a",   64'(io_a.done),   64'd0);
    chk("midreset_result_a", 64'(io_a.result), 64'd0);
    chk("midreset_ovf_a",    64'(io_a.ovf),    64'd0);
    repeat (2) step_a(1'b0, 0, 64'd0);
    rst_a = 1'b0;
    repeat (30) step_a(1'b0, rnd_x(), rnd_coef());
    run_a(3, C221, 25, 1'b0);

    // Random traffic on A, including back-to-back and while-busy starts.
    repeat (400) step_a($urandom_range(0, 9) < 2, rnd_x(), rnd_coef());
    repeat (LA + 3) step_a(1'b0, 0, 64'd0);

    // Degree-3 instance.
    run_b(10, {16'd1, 16'd0, 16'd0, 16'd0}, 1000, 1'b0);
    run_b(41, {16'd1, 16'd0, 16'd0, 16'd0}, 3385, 1'b1);
    repeat (8) begin
      cv = rnd_coef();
      xv = rnd_x();
      model(DB, cv, xv, r, o);
      run_b(xv, cv, r, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bo_horner.md
Name: bo_horner

Overview:
- Parametrised polynomial-evaluation datapath with its own control FSM. Successor to the fixed degree-2, A/B/C-parameter operative block, with the external control block folded in.
- Computes P(x) = c[N]*x^N + ... + c[1]*x + c[0] by Horner's method on a single shared adder, using an iterative shift-add multiplier.
- Adds a start/busy/done handshake, runtime-loadable coefficients and overflow reporting.
- result feeds the existing 7-segment display module unchanged.

Parameters:
- XW, 10, width of operand x (unsigned).
- W, 16, width of coefficients, accumulator and result (unsigned).
- DEGREE, 2, polynomial degree N; legal range 1..15.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  XW  operand; latched when start is accepted.
- coef  input  (DEGREE+1)*W  flattened coefficients; coef[W-1:0]=c[0], coef[(i+1)*W-1:i*W]=c[i]; latched when start is accepted.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  one-cycle pulse; result and ovf are valid.
- result  output  W  P(x) mod 2^W; held until the next accepted start.
- ovf  output  1  set if any intermediate value exceeded W bits; valid with done, held with result.

Behaviour:
- Reset (asynchronous, any state): state<=IDLE; busy=0, done=0, result=0, ovf=0; all internal registers cleared. An in-flight computation is discarded.
- FSM states: IDLE, MUL, ADD, DONE.
- IDLE:
  - start=1 at an edge: latch x into xr and coef into cr; S<=c[N]; idx<=N-1; bit<=0; acc<=0; ovf<=0; go to MUL.
  - start=0: stay in IDLE.
- MUL: one bit of xr per cycle, LSB first.
  - If xr[bit]=1, then acc<=acc+(S<<bit), with acc W+XW bits wide.
  - After bit=XW-1: go to ADD.
  - Each MUL phase lasts exactly XW cycles, independent of x.
- ADD:
  - sum = acc[W-1:0] + c[idx], W+1 bits wide.
  - S <= sum[W-1:0].
  - ovf <= ovf | (acc[W+XW-1:W]!=0) | sum[W].
  - If idx==0: go to DONE. Otherwise idx<=idx-1, bit<=0, acc<=0, go to MUL.
- DONE:
  - result and ovf registers update on the edge entering DONE.
  - done=1 for exactly one cycle; then IDLE.
- busy: high in MUL, ADD and DONE; low in IDLE. Implemented as a combinational decode of state.
- Latency: done is high in the cycle that begins DEGREE*(XW+1) edges after the edge accepting start. Default: 22 edges.
- Back-to-back: start may be accepted on the edge leaving DONE only if the FSM is in IDLE. Earliest next accept is 1 cycle after done.
- start while busy: ignored. x and coef changes while busy have no effect.
- Arithmetic: all unsigned; wrap modulo 2^W. ovf is sticky within one evaluation and cleared at accept.
- x=0: every MUL leaves acc=0, so result=c[0].

Decomposition:
- Shared include file bo_defs.vh:
  - state encoding localparams S_IDLE=2'd0, S_MUL=2'd1, S_ADD=2'd2, S_DONE=2'd3.
  - default widths XW_DEF=10 and W_DEF=16.
- One sub-module, seq_mult: the iterative shift-add multiplier.
  - Parameters W, XW.
  - Ports clock, reset, clr, step, a[W-1:0], b[XW-1:0], bit index, acc[W+XW-1:0].
- Coefficient mux and sequencing live in bo_horner.

Test Plan:
- Defaults, coef {c2,c1,c0}={2,2,1}, x=3, start pulse -> busy next cycle; done exactly 22 edges after accept; result=25; ovf=0.
- Same coefs, x=0 -> result=1, ovf=0; x=1 -> result=5, ovf=0; latency still 22 edges in both cases.
- Same coefs, x=1023 -> intermediate S=2048; result=63489 (2095105 mod 65536); ovf=1.
- Pulse start again 5 cycles after accept with x=7 -> ignored; first result=25 delivered; next accepted start with x=7 -> result=113.
- Assert reset at cycle 10 of an evaluation -> busy, done, result, ovf all 0 immediately; no done pulse follows; a fresh start with x=3 -> result=25.
- DEGREE=3 instance, coefs {1,0,0,0}, x=10 -> result=1000, ovf=0, latency 33 edges. Same instance with x=41 -> result=68921 mod 65536 = 3385, ovf=1.
